lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory transaction, byte/half/word
// access with alignment fault detection and load sign/zero extension.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] dmem_result,
    output logic [4:0]  rd_o,
    output logic        done_o,
    output logic        load_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        accept_s;
    logic        misaligned_s;
    logic [1:0]  addr_lo_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [4:0]  rd_pend_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [31:0] dmem_wdata_r;
    logic [3:0]  dmem_be_r;
    logic [31:0] result_r;
    logic [4:0]  rd_r;
    logic        done_r;
    logic        load_r;
    logic        misaligned_r;

    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lo[0];
            2'b10:   m = (lo != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << lo;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_f(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign req_ready    = (state_r == IDLE);
    assign accept_s     = req_valid && (state_r == IDLE);
    assign misaligned_s = misaligned_f(mem_size, addr_i[1:0]);

    assign dmem_req     = dmem_req_r;
    assign dmem_we      = dmem_we_r;
    assign dmem_addr    = dmem_addr_r;
    assign dmem_wdata   = dmem_wdata_r;
    assign dmem_be      = dmem_be_r;
    assign dmem_result  = result_r;
    assign rd_o         = rd_r;
    assign done_o       = done_r;
    assign load_o       = load_r;
    assign misaligned_o = misaligned_r;

    // Next-state selection for the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !misaligned_s) state_nxt_s = REQ;
                else                           state_nxt_s = IDLE;
            end
            REQ: begin
                if (dmem_gnt) state_nxt_s = dmem_we_r ? IDLE : WAIT;
                else          state_nxt_s = REQ;
            end
            WAIT: begin
                if (dmem_rvalid) state_nxt_s = IDLE;
                else             state_nxt_s = WAIT;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Request capture, memory-side outputs and completion reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_r    <= 2'b00;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            rd_pend_r    <= 5'd0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'd0;
            dmem_wdata_r <= 32'd0;
            dmem_be_r    <= 4'b0000;
            result_r     <= 32'd0;
            rd_r         <= 5'd0;
            done_r       <= 1'b0;
            load_r       <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            load_r       <= 1'b0;
            misaligned_r <= 1'b0;
            if (accept_s) begin
                if (misaligned_s) begin
                    misaligned_r <= 1'b1;
                end else begin
                    dmem_req_r   <= 1'b1;
                    dmem_we_r    <= mem_we;
                    dmem_addr_r  <= {addr_i[31:2], 2'b00};
                    dmem_wdata_r <= wdata_f(mem_size, wdata_i);
                    dmem_be_r    <= be_f(mem_size, addr_i[1:0]);
                    addr_lo_r    <= addr_i[1:0];
                    size_r       <= mem_size;
                    unsigned_r   <= mem_unsigned;
                    rd_pend_r    <= rd_i;
                end
            end
            if ((state_r == REQ) && dmem_gnt) begin
                dmem_req_r <= 1'b0;
                done_r     <= dmem_we_r;
            end
            // Read data is only meaningful once the request has been granted.
            if ((state_r == WAIT) && dmem_rvalid) begin
                result_r <= load_f(size_r, unsigned_r, addr_lo_r, dmem_rdata);
                rd_r     <= rd_pend_r;
                done_r   <= 1'b1;
                load_r   <= 1'b1;
            end
        end
    end

endmodule
